apb_timer_slave: RTL and testbench

APB_TIMER_SLAVE -- requirements
Module: apb_timer_slave

---
 rtl/apb_timer_slave.sv | 182 ++++++++++++++++++
 tb/tb_apb_timer_slave.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave.sv
// APB slave timer (CTRL/LOAD/COUNT/STATUS, level IRQ). Zero-wait access phase by default;
// APB_TIMER_WAIT_STATE_EN adds one PREADY=0 cycle per transfer, the only backpressure the slave applies.
module apb_timer_slave (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        PSELx,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        IRQ
);

`ifdef APB_TIMER_WAIT_STATE_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;
`endif

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LOAD   = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    state_t      r_state;
    state_t      w_state;

    logic        r_en;
    logic        r_auto_reload;
    logic        r_irq_en;
    logic        r_expired;
    logic [31:0] r_load;
    logic [31:0] r_count;

    logic        w_xfer;
    logic        w_addr_err;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_status;
    logic        w_expire;
    logic [1:0]  w_reg_sel;
    logic [31:0] w_rdata;
    logic        w_unused_paddr;

    // r_state holds last cycle's bus phase and w_state decodes this cycle's phase from it,
    // so PREADY can rise in the very first access cycle without waiting on a register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_comb begin
        w_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (PSELx && !PENABLE) begin
                    w_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (PSELx) begin
                    if (!PENABLE) begin
                        w_state = ST_SETUP;
                    end else begin
`ifdef APB_TIMER_WAIT_STATE_EN
                        w_state = ST_WAIT;
`else
                        w_state = ST_ACCESS;
`endif
                    end
                end
            end
`ifdef APB_TIMER_WAIT_STATE_EN
            ST_WAIT: begin
                if (PSELx && PENABLE) begin
                    w_state = ST_ACCESS;
                end
            end
`endif
            ST_ACCESS: begin
                if (PSELx && !PENABLE) begin
                    w_state = ST_SETUP;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign w_reg_sel      = PADDR[3:2];
    assign w_unused_paddr = ^PADDR[31:4];
    assign w_addr_err     = |PADDR[1:0];
    assign w_xfer         = (w_state == ST_ACCESS);
    assign w_wr           = w_xfer && PWRITE && !w_addr_err;
    assign w_wr_ctrl      = w_wr && (w_reg_sel == A_CTRL);
    assign w_wr_load      = w_wr && (w_reg_sel == A_LOAD);
    assign w_wr_status    = w_wr && (w_reg_sel == A_STATUS);
    assign w_expire       = r_en && (r_count == 32'd0);

    always_comb begin
        w_rdata = 32'h0;
        case (w_reg_sel)
            A_CTRL:   w_rdata = {29'd0, r_irq_en, r_auto_reload, r_en};
            A_LOAD:   w_rdata = r_load;
            A_COUNT:  w_rdata = r_count;
            A_STATUS: w_rdata = {31'd0, r_expired};
            default:  w_rdata = 32'h0;
        endcase
    end

    assign PREADY  = w_xfer;
    assign PSLVERR = w_xfer && w_addr_err;
    assign PRDATA  = (w_xfer && !w_addr_err) ? w_rdata : 32'h0;
    assign IRQ     = r_expired && r_irq_en;

    // A CTRL write in the expiry cycle takes precedence over the one-shot EN clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_en          <= 1'b0;
            r_auto_reload <= 1'b0;
            r_irq_en      <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en          <= PWDATA[0];
            r_auto_reload <= PWDATA[1];
            r_irq_en      <= PWDATA[2];
        end else if (w_expire && !r_auto_reload) begin
            r_en          <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_load <= 32'h0;
        end else if (w_wr_load) begin
            r_load <= PWDATA;
        end
    end

    // Software LOAD writes override both the decrement and the auto-reload of the same edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_count <= 32'h0;
        end else if (w_wr_load) begin
            r_count <= PWDATA;
        end else if (r_en) begin
            if (r_count != 32'd0) begin
                r_count <= r_count - 32'd1;
            end else if (r_auto_reload) begin
                r_count <= r_load;
            end
        end
    end

    // An expiry beats a same-cycle write-1-to-clear so no event is lost.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_expired <= 1'b0;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end else if (w_wr_status && PWDATA[0]) begin
            r_expired <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: directed APB transfers, expectations queued at issue and
// checked by a separate completion monitor; timer-side checks use cycle stamps.
module tb_apb_timer_slave;

`ifdef APB_TIMER_WAIT_STATE_EN
    localparam int ACC = 2;
`else
    localparam int ACC = 1;
`endif

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        PSELx   = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [31:0] PADDR   = 32'h0;
    logic [31:0] PWDATA  = 32'h0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        IRQ;

    typedef struct {
        int          id;
        bit          err;
        bit          cd;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_chk     = 0;
    int          n_fail    = 0;
    int          xid       = 0;
    int          last_done = 0;
    int          cyc       = 0;
    int          d_one;
    int          d_ar;
    int          c;
    logic [31:0] e;
    logic [3:0]  tbl [8] = '{4'h8, 4'h8, 4'hC, 4'hC, 4'h0, 4'h0, 4'h8, 4'hC};

    apb_timer_slave dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .PSELx   (PSELx),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .IRQ     (IRQ)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge HCLK) begin
        if (HRESETn && PSELx && PENABLE && PREADY) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_completion: addr 0x%08h completed, required no transfer", PADDR);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("pslverr[%0d]", mon_e.id), {31'd0, PSLVERR}, {31'd0, mon_e.err});
                if (mon_e.cd) chk($sformatf("prdata[%0d]", mon_e.id), PRDATA, mon_e.dat);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that ends the transfer.
    task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wdat,
                       input bit cd, input logic [31:0] erd, input bit eerr);
        exp_t x;
        int   n;
        x.id  = xid;
        x.err = eerr;
        x.cd  = cd;
        x.dat = erd;
        xid++;
        exp_q.push_back(x);
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdat;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        n = 1;
        @(negedge HCLK);
        while (!PREADY && n < 8) begin
            @(posedge HCLK); #1;
            n++;
            @(negedge HCLK);
        end
        if (!PREADY) begin
            n_chk++;
            n_fail++;
            $display("FAIL pready_timeout[%0d]: PREADY still 0 after %0d cycles, required within %0d", x.id, n, ACC);
            x = exp_q.pop_back();
        end else begin
            chk($sformatf("access_len[%0d]", x.id), 32'(n), 32'(ACC));
        end
        last_done = cyc;
        @(posedge HCLK); #1;
        PSELx   = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] dat);
        apb(1'b1, addr, dat, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        apb(1'b0, addr, 32'h0, 1'b1, exp, 1'b0);
    endtask

    task automatic idle(input int n);
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        repeat (n) begin
            @(posedge HCLK); #1;
        end
    endtask

    // Idle until a transfer issued now completes in auto-reload phase p (3 = expiry cycle).
    task automatic idle_until(input int p);
        for (int k = 0; k < 4; k++) begin
            if (((cyc + ACC - d_ar - 1) % 4) != p) idle(1);
        end
    endtask

    function automatic logic [31:0] cnt_once(input int l, input int d, input int cc);
        int k;
        k = cc - d - 1;
        return (k >= l) ? 32'd0 : 32'(l - k);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        // Reset with a bus access held active: nothing may complete.
        PSELx   = 1'b1;
        PENABLE = 1'b1;
        @(posedge HCLK); #1;
        chk("rst_pready",  {31'd0, PREADY},  32'd0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        chk("rst_prdata",  PRDATA,           32'd0);
        chk("rst_irq",     {31'd0, IRQ},     32'd0);
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        rd(32'h0, 32'h0);
        rd(32'h4, 32'h0);
        rd(32'h8, 32'h0);
        rd(32'hC, 32'h0);

        // Back-to-back write/read, CTRL reserved bits.
        wr(32'h4, 32'hDEADBEEF);
        rd(32'h4, 32'hDEADBEEF);
        rd(32'h8, 32'hDEADBEEF);
        wr(32'h0, 32'hFFFF_FFF6);
        rd(32'h0, 32'h6);
        wr(32'h0, 32'h0);
        rd(32'h0, 32'h0);

        // Misaligned accesses, read-only COUNT, ignored upper address bits.
        apb(1'b0, 32'h6, 32'h0, 1'b1, 32'h0, 1'b1);
        apb(1'b1, 32'h5, 32'h1234, 1'b0, 32'h0, 1'b1);
        rd(32'h4, 32'hDEADBEEF);
        wr(32'h8, 32'h99);
        rd(32'h8, 32'hDEADBEEF);
        rd(32'hFFFF_FFF4, 32'hDEADBEEF);

        // Select dropped after the setup phase.
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'hBAD0BAD0;
        @(posedge HCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b1;
        @(posedge HCLK); #1;
        PENABLE = 1'b0;
        rd(32'h4, 32'hDEADBEEF);

        // One-shot countdown from 5.
        wr(32'h4, 32'h5);
        idle(3);
        rd(32'h8, 32'h5);
        wr(32'h0, 32'h1);
        d_one = last_done;
        for (int i = 0; i < 8; i++) begin
            c = cyc + ACC;
            case (tbl[i])
                4'h8:    e = cnt_once(5, d_one, c);
                4'hC:    e = (c >= d_one + 7) ? 32'd1 : 32'd0;
                default: e = (c <= d_one + 6) ? 32'd1 : 32'd0;
            endcase
            rd({28'd0, tbl[i]}, e);
        end
        @(negedge HCLK);
        chk("oneshot_irq_off", {31'd0, IRQ}, 32'd0);
        @(posedge HCLK); #1;

        // Auto-reload with interrupt, period 4.
        wr(32'h4, 32'h3);
        wr(32'hC, 32'h1);
        wr(32'h0, 32'h7);
        d_ar = last_done;
        for (int i = 1; i <= 10; i++) begin
            @(negedge HCLK);
            chk($sformatf("irq_periodic_c%0d", i), {31'd0, IRQ}, (cyc >= d_ar + 5) ? 32'd1 : 32'd0);
            @(posedge HCLK); #1;
        end
        for (int i = 0; i < 4; i++) begin
            rd(32'h8, 32'(3 - ((cyc + ACC - d_ar - 1) % 4)));
        end
        idle_until(0);
        wr(32'hC, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge HCLK);
            chk($sformatf("irq_after_clear_c%0d", i), {31'd0, IRQ}, (i == 4) ? 32'd1 : 32'd0);
            @(posedge HCLK); #1;
        end

        // Clear landing on an expiry: the set must win.
        idle_until(0);
        wr(32'hC, 32'h1);
        idle_until(3);
        wr(32'hC, 32'h1);
        @(negedge HCLK);
        chk("irq_set_wins", {31'd0, IRQ}, 32'd1);
        @(posedge HCLK); #1;
        rd(32'hC, 32'h1);

        // LOAD write landing on the reload cycle.
        idle_until(3);
        wr(32'h4, 32'h10);
        rd(32'h8, 32'(16 - ACC));
        rd(32'h4, 32'h10);

        // Reset in the middle of an access with COUNT=0x20 and IRQ high.
        wr(32'h0, 32'h6);
        wr(32'h4, 32'h20);
        rd(32'h8, 32'h20);
        @(negedge HCLK);
        chk("pre_reset_irq", {31'd0, IRQ}, 32'd1);
        @(posedge HCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h55;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        #2;
        HRESETn = 1'b0;
        #1;
        chk("midrst_pready",  {31'd0, PREADY},  32'd0);
        chk("midrst_pslverr", {31'd0, PSLVERR}, 32'd0);
        chk("midrst_prdata",  PRDATA,           32'd0);
        chk("midrst_irq",     {31'd0, IRQ},     32'd0);
        repeat (2) begin
            @(posedge HCLK); #1;
        end
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        rd(32'h8, 32'h0);
        rd(32'h4, 32'h0);
        rd(32'h0, 32'h0);
        rd(32'hC, 32'h0);

        idle(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
